// File: rtl/mem_arbiter.sv
// Two-initiator (instruction fetch / load-store) arbiter onto one physical memory port.
// Optional build macro ARB_ROUND_ROBIN_EN replaces fixed D-over-I priority with alternating priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_read,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_resp,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDR_WIDTH-1:0]   d_address,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_mbe,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_resp,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [ADDR_WIDTH-1:0]   pmem_address,
    output logic [DATA_WIDTH-1:0]   pmem_wdata,
    output logic [DATA_WIDTH/8-1:0] pmem_mbe,
    input  logic [DATA_WIDTH-1:0]   pmem_rdata,
    input  logic                    pmem_resp
);

    localparam int MBE_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BUSY_I = 3'd1;
    localparam logic [2:0] BUSY_D = 3'd2;
    localparam logic [2:0] DONE_I = 3'd3;
    localparam logic [2:0] DONE_D = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [MBE_WIDTH-1:0]  mbe_q;
    logic                  write_q;
    logic                  d_req;
    logic                  grant_d;
    logic                  busy;

    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D was served last. Resetting to D lets I win the first tie after reset.
    logic last_grant;

    always_comb begin
        grant_d = d_req && (!i_read || !last_grant);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (state == IDLE) begin
            if (grant_d) begin
                last_grant <= 1'b1;
            end else if (i_read) begin
                last_grant <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mbe_q   <= '0;
            write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A simultaneous read+write from D is latched as a write.
                    if (grant_d) begin
                        addr_q  <= d_address;
                        wdata_q <= d_wdata;
                        mbe_q   <= d_mbe;
                        write_q <= d_write;
                        state   <= BUSY_D;
                    end else if (i_read) begin
                        addr_q  <= i_address;
                        write_q <= 1'b0;
                        state   <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (pmem_resp) begin
                        rdata_q <= pmem_rdata;
                        state   <= DONE_I;
                    end
                end
                BUSY_D: begin
                    if (pmem_resp) begin
                        rdata_q <= write_q ? '0 : pmem_rdata;
                        state   <= DONE_D;
                    end
                end
                DONE_I, DONE_D: begin
                    rdata_q <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // pmem side is decoded purely from state and latched registers.
    assign busy         = (state == BUSY_I) || (state == BUSY_D);
    assign pmem_read    = (state == BUSY_I) || ((state == BUSY_D) && !write_q);
    assign pmem_write   = (state == BUSY_D) && write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign pmem_mbe     = busy ? (pmem_write ? mbe_q : '1) : '0;

    assign i_resp  = (state == DONE_I);
    assign d_resp  = (state == DONE_D);
    assign i_rdata = i_resp ? rdata_q : '0;
    assign d_rdata = d_resp ? rdata_q : '0;

endmodule
